// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory port, redirect/halt controls
// and the opcode valid/ready handshake toward the decoder.
interface fetch_unit_if #(
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 12
);
  logic                imem_en;
  logic [ADDR_W-1:0]   imem_addr;
  logic [OPCODE_W-1:0] imem_rdata;
  logic                jump_en;
  logic [ADDR_W-1:0]   jump_target;
  logic                halt;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   opcode_pc;
  logic                opcode_valid;
  logic                opcode_ready;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    input  jump_en,
    input  jump_target,
    input  halt,
    output opcode,
    output opcode_pc,
    output opcode_valid,
    input  opcode_ready
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    output jump_en,
    output jump_target,
    output halt,
    input  opcode,
    input  opcode_pc,
    input  opcode_valid,
    output opcode_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sync-read imem issue, 2-entry opcode
// queue with valid/ready to the decoder, jump redirect and halt.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 12,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_iss_pc;
  logic                r_inflight;
  logic                r_epoch;
  logic                r_iss_epoch;
  logic [1:0]          r_count;
  logic [OPCODE_W-1:0] r_q_op [2];
  logic [ADDR_W-1:0]   r_q_pc [2];

  logic       w_pop;
  logic       w_push;
  logic [1:0] w_occ;
  logic       w_issue;
  logic       w_widx;

  assign w_pop  = (r_count != 2'd0) && bus.opcode_ready;
  assign w_push = r_inflight && (r_iss_epoch == r_epoch);

  // Occupancy once this edge's return and transfer settle; a
  // returning read is already counted via push, so an issue
  // is allowed only if its data will find a free slot.
  assign w_occ  = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_widx = r_count[1] | (r_count[0] & ~w_pop);

  assign w_issue = (r_state == S_RUN) && !bus.jump_en
                   && (w_occ < 2'd2);

  assign bus.imem_en      = w_issue;
  assign bus.imem_addr    = r_pc;
  assign bus.opcode       = r_q_op[0];
  assign bus.opcode_pc    = r_q_pc[0];
  assign bus.opcode_valid = (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= ADDR_W'(RESET_PC);
      r_iss_pc    <= '0;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_iss_epoch <= 1'b0;
      r_count     <= 2'd0;
      r_q_op[0]   <= '0;
      r_q_op[1]   <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_RUN;
        S_RUN:    if (bus.halt) r_state <= S_HALTED;
        S_HALTED: if (!bus.halt) r_state <= S_RUN;
        default:  r_state <= S_IDLE;
      endcase

      if (bus.jump_en) begin
        // Head handshake this cycle still completes; rest is dropped.
        r_pc       <= bus.jump_target;
        r_epoch    <= ~r_epoch;
        r_count    <= 2'd0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        r_count    <= w_occ;
        if (w_issue) begin
          r_pc        <= r_pc + 1'b1;
          r_iss_pc    <= r_pc;
          r_iss_epoch <= r_epoch;
        end
        if (w_pop) begin
          r_q_op[0] <= r_q_op[1];
          r_q_pc[0] <= r_q_pc[1];
        end
        if (w_push) begin
          r_q_op[w_widx] <= bus.imem_rdata;
          r_q_pc[w_widx] <= r_iss_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, backpressure, jump,
// PC wrap, halt/resume and mid-run reset against mem[i]=12'h100+i.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mem_of(logic [7:0] a);
    return 12'h100 + {4'h0, a};
  endfunction

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= mem_of(bus.imem_addr);

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic head(string tag, int pc);
    logic [7:0] p;
    p = 8'(pc);
    check({tag, "_vld"}, 32'(bus.opcode_valid), 32'd1);
    check({tag, "_pc"}, 32'(bus.opcode_pc), 32'(p));
    check({tag, "_op"}, 32'(bus.opcode), 32'(mem_of(p)));
  endtask

  task automatic no_valid(string tag);
    check({tag, "_vld"}, 32'(bus.opcode_valid), 32'd0);
  endtask

  // Hold reset, check reset outputs, release on a negedge (cycle 0).
  task automatic do_reset(string tag);
    rst_n = 1'b0;
    tick();
    check({tag, "_rvld"}, 32'(bus.opcode_valid), 32'd0);
    check({tag, "_rop"}, 32'(bus.opcode), 32'd0);
    check({tag, "_rpc"}, 32'(bus.opcode_pc), 32'd0);
    check({tag, "_ren"}, 32'(bus.imem_en), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check({tag, "_c0en"}, 32'(bus.imem_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.jump_en      = 1'b0;
    bus.jump_target  = 8'h00;
    bus.halt         = 1'b0;
    bus.opcode_ready = 1'b1;

    // 1: first fetch latency and streaming
    do_reset("t1");
    tick();
    check("t1_c1en", 32'(bus.imem_en), 32'd1);
    check("t1_c1addr", 32'(bus.imem_addr), 32'h00);
    no_valid("t1_c1");
    tick();
    no_valid("t1_c2");
    tick(); head("t1_c3", 0);
    tick(); head("t1_c4", 1);
    tick(); head("t1_c5", 2);

    // 2: backpressure fills the queue, then drains without gaps
    bus.opcode_ready = 1'b0;
    do_reset("t2");
    repeat (3) tick();
    head("t2_c3", 0);
    tick(); head("t2_c4", 0);
    check("t2_c4en", 32'(bus.imem_en), 32'd0);
    repeat (3) tick();
    head("t2_c7", 0);
    check("t2_c7en", 32'(bus.imem_en), 32'd0);
    bus.opcode_ready = 1'b1;
    #1;
    check("t2_c7en_rdy", 32'(bus.imem_en), 32'd1);
    tick(); head("t2_c8", 1);
    tick(); head("t2_c9", 2);
    tick(); head("t2_c10", 3);

    // 3: jump with head queued and a read in flight
    do_reset("t3");
    repeat (4) tick();
    head("t3_c4", 1);
    bus.jump_en     = 1'b1;
    bus.jump_target = 8'h40;
    #1;
    check("t3_jmp_en", 32'(bus.imem_en), 32'd0);
    tick();
    bus.jump_en = 1'b0;
    #1;
    no_valid("t3_c5");
    check("t3_c5en", 32'(bus.imem_en), 32'd1);
    check("t3_c5addr", 32'(bus.imem_addr), 32'h40);
    tick(); no_valid("t3_c6");
    tick(); head("t3_c7", 8'h40);
    tick(); head("t3_c8", 8'h41);

    // 4: PC wrap FE, FF, 00, 01
    bus.jump_en     = 1'b1;
    bus.jump_target = 8'hFE;
    tick();
    bus.jump_en = 1'b0;
    no_valid("t4_c9");
    tick();
    tick(); head("t4_c11", 8'hFE);
    tick(); head("t4_c12", 8'hFF);
    tick(); head("t4_c13", 8'h00);
    tick(); head("t4_c14", 8'h01);

    // 5: halt stops issue, queue drains, resume at next pc
    bus.halt = 1'b1;
    #1;
    check("t5_c14en", 32'(bus.imem_en), 32'd1);
    tick(); head("t5_c15", 8'h02);
    check("t5_c15en", 32'(bus.imem_en), 32'd0);
    tick(); head("t5_c16", 8'h03);
    check("t5_c16en", 32'(bus.imem_en), 32'd0);
    tick(); no_valid("t5_c17");
    check("t5_c17en", 32'(bus.imem_en), 32'd0);
    tick(); no_valid("t5_c18");
    bus.halt = 1'b0;
    tick();
    check("t5_c19en", 32'(bus.imem_en), 32'd1);
    check("t5_c19addr", 32'(bus.imem_addr), 32'h04);
    tick(); no_valid("t5_c20");
    tick(); head("t5_c21", 8'h04);
    tick(); head("t5_c22", 8'h05);

    // 6: reset mid-stream clears outputs at once and restarts
    rst_n = 1'b0;
    #1;
    check("t6_vld", 32'(bus.opcode_valid), 32'd0);
    check("t6_op", 32'(bus.opcode), 32'd0);
    check("t6_pc", 32'(bus.opcode_pc), 32'd0);
    check("t6_en", 32'(bus.imem_en), 32'd0);
    do_reset("t6");
    tick(); no_valid("t6_c1");
    tick(); no_valid("t6_c2");
    tick(); head("t6_c3", 0);
    tick(); head("t6_c4", 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
